// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
// Holds the parity-mode encodings, the receiver FSM state type and the
// half-bit timing helper used to place the start-bit sample.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

  // Clock offset from the start edge to the middle of the start bit.
  function automatic int clks_half(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for a single asynchronous input.
// RST_VAL sets the value both stages take in reset so that an idle-high
// line does not look like an edge when reset is released.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; only q is used by downstream logic.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (data width, parity, stop bits).
// Reports parity and framing errors, drops start-bit glitches and waits
// for the line to return high after a break so it produces one frame only.
//
// Optional build macro UART_RX_MAJORITY_VOTE_EN: every bit decision becomes
// a 2-of-3 vote over three consecutive samples centred on the bit middle;
// the decision (and therefore DV) lands one clock later.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | line idle, waiting for rx_s low
// ST_START     | timing to mid start bit, confirm it is still low
// ST_DATA      | sampling DATA_BITS data bits, LSB first
// ST_PARITY    | sampling the parity bit (only when PARITY != none)
// ST_STOP      | sampling STOP_BITS stop bits, low sample = framing error
// ST_DONE      | one cycle, DV high, outputs just loaded
// ST_WAIT_HIGH | framing error with line still low (break), wait for high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Rx_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_DLY = 1;
`else
  localparam int VOTE_DLY = 0;
`endif

  // The counter is cleared in the IDLE cycle that sees the edge, so a
  // count of HALF-1 in START lands exactly HALF clocks after that cycle.
  // With voting the decision moves one clock later; data/parity/stop
  // decisions then follow at full bit spacing from there.
  localparam logic [CNT_W-1:0] START_TC = CNT_W'(clks_half(CLKS_PER_BIT) - 1 + VOTE_DLY);
  localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP  = (STOP_BITS == 2);
  localparam logic             HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic             ODD_PARITY = (PARITY == PARITY_ODD);

  logic                 rx_s;
  logic                 bit_val;
  rx_state_e            state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err;
  logic                 frame_err;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .d       (i_Rx_Serial),
    .q       (rx_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_hist;

  // Keep the two previous line samples so a decision at count D can vote
  // over counts D-2, D-1 and D.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      vote_hist <= 2'b11;
    end else begin
      vote_hist <= {vote_hist[0], rx_s};
    end
  end

  assign bit_val = (vote_hist[1] & vote_hist[0]) |
                   (vote_hist[1] & rx_s) |
                   (vote_hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // Receive sequencer: bit timing, deframing, error flags and outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= ST_IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shift_reg    <= '0;
      par_err      <= 1'b0;
      frame_err    <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Rx_Busy    <= 1'b0;
    end else begin
      o_Rx_DV <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          if (!rx_s) begin
            state     <= ST_START;
            o_Rx_Busy <= 1'b1;
          end
        end

        ST_START: begin
          if (clk_cnt == START_TC) begin
            clk_cnt <= '0;
            if (!bit_val) begin
              state     <= ST_DATA;
              bit_idx   <= '0;
              stop_idx  <= 1'b0;
              par_err   <= 1'b0;
              frame_err <= 1'b0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state     <= ST_IDLE;
              o_Rx_Busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (clk_cnt == BIT_TC) begin
            clk_cnt   <= '0;
            shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              state <= HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (clk_cnt == BIT_TC) begin
            clk_cnt <= '0;
            // Even: error on odd overall count; odd: error on even count.
            par_err <= (^shift_reg) ^ bit_val ^ ODD_PARITY;
            state   <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (clk_cnt == BIT_TC) begin
            clk_cnt <= '0;
            if (stop_idx == LAST_STOP) begin
              state        <= ST_DONE;
              o_Rx_DV      <= 1'b1;
              o_Rx_Byte    <= shift_reg;
              o_Parity_Err <= HAS_PARITY & par_err;
              o_Frame_Err  <= frame_err | ~bit_val;
            end else begin
              stop_idx  <= 1'b1;
              frame_err <= frame_err | ~bit_val;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // A low line after a framing error is a break; do not re-arm
          // on it or every bit period would start a new frame.
          if (o_Frame_Err && !rx_s) begin
            state <= ST_WAIT_HIGH;
          end else begin
            state     <= ST_IDLE;
            o_Rx_Busy <= 1'b0;
          end
        end

        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state     <= ST_IDLE;
            o_Rx_Busy <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          o_Rx_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receiver configurations (8N1, 8E1, 7O2) driven from
// their own serial lines at 87 clocks per bit, checked against a frame-level
// reference model (expected data, parity and framing flags, DV counts).
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_line;

  logic       dv_a, dv_b, dv_c;
  logic [7:0] byte_a, byte_b;
  logic [6:0] byte_c;
  logic       pe_a, pe_b, pe_c;
  logic       fe_a, fe_b, fe_c;
  logic       busy_a, busy_b, busy_c;

  logic [2:0] dv_w, pe_w, fe_w, busy_w;
  logic [8:0] byte_w [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #50 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB)) u_dut_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[0]),
    .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a), .o_Parity_Err(pe_a),
    .o_Frame_Err(fe_a), .o_Rx_Busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(PARITY_EVEN)) u_dut_8e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[1]),
    .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b), .o_Parity_Err(pe_b),
    .o_Frame_Err(fe_b), .o_Rx_Busy(busy_b));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PARITY_ODD), .STOP_BITS(2)) u_dut_7o2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[2]),
    .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c), .o_Parity_Err(pe_c),
    .o_Frame_Err(fe_c), .o_Rx_Busy(busy_c));

  assign dv_w      = {dv_c, dv_b, dv_a};
  assign pe_w      = {pe_c, pe_b, pe_a};
  assign fe_w      = {fe_c, fe_b, fe_a};
  assign busy_w    = {busy_c, busy_b, busy_a};
  assign byte_w[0] = {1'b0, byte_a};
  assign byte_w[1] = {1'b0, byte_b};
  assign byte_w[2] = {2'b00, byte_c};

  // Channel configuration as the bench sees it.
  function automatic int dbits(input int ch);
    return (ch == 2) ? 7 : 8;
  endfunction
  function automatic int pmode(input int ch);
    return (ch == 0) ? PARITY_NONE : ((ch == 1) ? PARITY_EVEN : PARITY_ODD);
  endfunction
  function automatic int nstop(input int ch);
    return (ch == 2) ? 2 : 1;
  endfunction
  function automatic logic [8:0] mask_of(input int ch);
    return 9'((1 << dbits(ch)) - 1);
  endfunction

  // Reference model: parity bit a correct transmitter would send.
  function automatic logic good_pbit(input int ch, input logic [8:0] data);
    int ones;
    ones = $countones(data & mask_of(ch));
    if (pmode(ch) == PARITY_ODD) return ((ones % 2) == 0);
    return ((ones % 2) == 1);
  endfunction

  function automatic logic exp_perr(input int ch, input logic [8:0] data, input logic pbit);
    int total;
    if (pmode(ch) == PARITY_NONE) return 1'b0;
    total = $countones(data & mask_of(ch)) + int'(pbit);
    if (pmode(ch) == PARITY_EVEN) return ((total % 2) == 1);
    return ((total % 2) == 0);
  endfunction

  function automatic logic exp_ferr(input int ch, input logic [1:0] stop_lvl);
    if (stop_lvl[0] == 1'b0) return 1'b1;
    if (nstop(ch) == 2 && stop_lvl[1] == 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: count DV pulses and keep the last two frames per channel.
  int         cyc = 0;
  int         dv_cnt   [3] = '{0, 0, 0};
  int         last_cyc [3] = '{0, 0, 0};
  int         prev_cyc [3] = '{0, 0, 0};
  logic [8:0] last_byte[3] = '{9'd0, 9'd0, 9'd0};
  logic [8:0] prev_byte[3] = '{9'd0, 9'd0, 9'd0};
  logic       last_pe  [3] = '{1'b0, 1'b0, 1'b0};
  logic       last_fe  [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv_w[i]) begin
        dv_cnt[i]    <= dv_cnt[i] + 1;
        prev_cyc[i]  <= last_cyc[i];
        last_cyc[i]  <= cyc;
        prev_byte[i] <= last_byte[i];
        last_byte[i] <= byte_w[i];
        last_pe[i]   <= pe_w[i];
        last_fe[i]   <= fe_w[i];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drive(input int ch, input logic v);
    rx_line[ch] = v;
  endtask

  // Drive one frame starting at the current negedge; no trailing idle.
  task automatic send_frame(input int ch, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stop_lvl);
    drive(ch, 1'b0);
    bit_time();
    for (int k = 0; k < dbits(ch); k++) begin
      drive(ch, data[k]);
      bit_time();
    end
    if (pmode(ch) != PARITY_NONE) begin
      drive(ch, pbit);
      bit_time();
    end
    for (int s = 0; s < nstop(ch); s++) begin
      drive(ch, stop_lvl[s]);
      bit_time();
    end
  endtask

  task automatic frame_check(input int ch, input logic [8:0] data, input logic pbit,
                             input logic [1:0] stop_lvl, input string tag);
    int c0;
    c0 = dv_cnt[ch];
    send_frame(ch, data, pbit, stop_lvl);
    drive(ch, 1'b1);
    repeat (2) bit_time();
    check_val({tag, "_dv_count"}, 32'(dv_cnt[ch] - c0), 32'd1);
    check_val({tag, "_byte"}, 32'(last_byte[ch]), 32'(data & mask_of(ch)));
    check_val({tag, "_perr"}, 32'(last_pe[ch]), 32'(exp_perr(ch, data, pbit)));
    check_val({tag, "_ferr"}, 32'(last_fe[ch]), 32'(exp_ferr(ch, stop_lvl)));
  endtask

  task automatic check_idle_outputs(input int ch, input string tag);
    check_val({tag, "_dv"},   32'(dv_w[ch]),   32'd0);
    check_val({tag, "_byte"}, 32'(byte_w[ch]), 32'd0);
    check_val({tag, "_perr"}, 32'(pe_w[ch]),   32'd0);
    check_val({tag, "_ferr"}, 32'(fe_w[ch]),   32'd0);
    check_val({tag, "_busy"}, 32'(busy_w[ch]), 32'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c0, t0, lat, busy_low, k;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stop_lvl;

    rst     = 1'b1;
    rx_line = 3'b111;
    repeat (3) @(negedge clk);
    for (int ch = 0; ch < 3; ch++) check_idle_outputs(ch, $sformatf("reset_ch%0d", ch));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0x3F, with DV latency from the start edge.
    t0 = cyc;
    frame_check(0, 9'h03F, 1'b0, 2'b11, "8n1_3f");
    lat = last_cyc[0] - t0;
    check_val("8n1_lat_max", 32'(lat <= 10 * CPB + 4), 32'd1);
    check_val("8n1_lat_min", 32'(lat >= 9 * CPB), 32'd1);

    // Even parity: 0xA5 has four ones, so parity bit 0 is correct.
    frame_check(1, 9'h0A5, 1'b0, 2'b11, "8e1_a5_p0");
    frame_check(1, 9'h0A5, 1'b1, 2'b11, "8e1_a5_p1");

    // Break: stop bit low then line held low for 20 bit times.
    c0 = dv_cnt[0];
    send_frame(0, 9'h081, 1'b0, 2'b00);
    busy_low = 0;
    repeat (20 * CPB) begin
      @(negedge clk);
      if (!busy_w[0]) busy_low++;
    end
    check_val("break_dv_count", 32'(dv_cnt[0] - c0), 32'd1);
    check_val("break_byte", 32'(last_byte[0]), 32'h81);
    check_val("break_ferr", 32'(last_fe[0]), 32'd1);
    check_val("break_busy_low_cycles", 32'(busy_low), 32'd0);
    drive(0, 1'b1);
    repeat (2) bit_time();
    check_val("break_busy_release", 32'(busy_w[0]), 32'd0);
    frame_check(0, 9'h042, 1'b0, 2'b11, "after_break_42");

    // Start-bit glitch: 30 clocks low must not produce a frame.
    c0 = dv_cnt[0];
    drive(0, 1'b0);
    repeat (30) @(negedge clk);
    check_val("glitch_busy_seen", 32'(busy_w[0]), 32'd1);
    drive(0, 1'b1);
    for (k = 0; k < 45 && busy_w[0]; k++) @(negedge clk);
    check_val("glitch_busy_release", 32'(busy_w[0]), 32'd0);
    repeat (2) bit_time();
    check_val("glitch_dv_count", 32'(dv_cnt[0] - c0), 32'd0);

    // Reset after data bit 3 of 0xC3 abandons the frame.
    c0   = dv_cnt[0];
    data = 9'h0C3;
    drive(0, 1'b0);
    bit_time();
    for (int b = 0; b < 4; b++) begin
      drive(0, data[b]);
      bit_time();
    end
    rst = 1'b1;
    drive(0, 1'b1);
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "midreset");
    rst = 1'b0;
    repeat (2) bit_time();
    check_val("midreset_dv_count", 32'(dv_cnt[0] - c0), 32'd0);
    frame_check(0, 9'h05A, 1'b0, 2'b11, "after_reset_5a");

    // 7O2 back-to-back: frame is start + 7 data + parity + 2 stop = 11 bits.
    c0 = dv_cnt[2];
    send_frame(2, 9'h000, good_pbit(2, 9'h000), 2'b11);
    send_frame(2, 9'h07F, good_pbit(2, 9'h07F), 2'b11);
    drive(2, 1'b1);
    repeat (2) bit_time();
    check_val("b2b_dv_count", 32'(dv_cnt[2] - c0), 32'd2);
    check_val("b2b_byte0", 32'(prev_byte[2]), 32'h00);
    check_val("b2b_byte1", 32'(last_byte[2]), 32'h7F);
    check_val("b2b_perr", 32'(last_pe[2]), 32'd0);
    check_val("b2b_spacing", 32'(last_cyc[2] - prev_cyc[2]),
              32'((1 + dbits(2) + 1 + nstop(2)) * CPB));

    // Randomised frames on every configuration.
    for (int ch = 0; ch < 3; ch++) begin
      for (int n = 0; n < 6; n++) begin
        data     = 9'($urandom) & mask_of(ch);
        pbit     = good_pbit(ch, data) ^ ($urandom_range(0, 3) == 0);
        stop_lvl = 2'b11;
        if ($urandom_range(0, 3) == 0) stop_lvl[$urandom_range(0, nstop(ch) - 1)] = 1'b0;
        repeat ($urandom_range(1, 60)) @(negedge clk);
        frame_check(ch, data, pbit, stop_lvl, $sformatf("rnd_ch%0d_%0d", ch, n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
